// File: rtl/max_frame_reducer_if.sv
// Stream bundle for max_frame_reducer: the sample input stream and the reduced-result output stream.
// The master side drives samples and out_ready. The slave side is the reducer itself.
interface max_frame_reducer_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_count
  );
endinterface

// File: rtl/max_frame_reducer.sv
// Reduces each frame of unsigned samples to (max, first index of max, count).
// The result is posted through a one-entry registered output buffer with valid/ready backpressure.
module max_frame_reducer #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3
) (
  input logic              clk,
  input logic              rst,
  max_frame_reducer_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [WIDTH-1:0] run_max_q;
  logic [IDX_W-1:0] run_idx_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_max_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W:0]   out_count_q;

  logic             in_ready;
  logic             accept;
  logic             xfer;
  logic             close;
  logic             take;
  logic [WIDTH-1:0] max_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W:0]   count_d;
  logic [IDX_W-1:0] cnt_d;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_q && bus.out_ready;
  assign close    = accept && (bus.in_last || (cnt_q == LAST_IDX));

  // The first sample of a frame always seeds the running max. After that only a
  // strictly larger sample replaces it, so ties keep the earlier index.
  always_comb begin
    take    = (state_q == IDLE) || (bus.in_data > run_max_q);
    max_d   = take ? bus.in_data : run_max_q;
    idx_d   = (state_q == IDLE) ? '0 : (take ? cnt_q : run_idx_q);
    count_d = {1'b0, cnt_q} + (IDX_W+1)'(1);
    cnt_d   = cnt_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b0;
      end
      // A close in the same cycle as a transfer reloads the buffer and keeps it valid.
      if (close) begin
        out_valid_q <= 1'b1;
        out_max_q   <= max_d;
        out_idx_q   <= idx_d;
        out_count_q <= count_d;
        cnt_q       <= '0;
        state_q     <= IDLE;
      end else if (accept) begin
        run_max_q <= max_d;
        run_idx_q <= idx_d;
        cnt_q     <= cnt_d;
        state_q   <= ACCUM;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_max_frame_reducer.sv
// Bench for max_frame_reducer: directed test-plan sequences, then random traffic.
// All traffic is checked against a frame-queue reference model.
module tb_max_frame_reducer;
  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  logic clk;
  logic rst;

  max_frame_reducer_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  max_frame_reducer #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: the samples of the open frame, plus the posted result.
  logic [WIDTH-1:0] frame[$];
  logic             m_valid;
  logic [31:0]      m_max;
  logic [31:0]      m_idx;
  logic [31:0]      m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    m_valid = 1'b0;
    m_max   = 0;
    m_idx   = 0;
    m_count = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
    check({tag, ".out_max"},   32'(bus.out_max),   m_max);
    check({tag, ".out_idx"},   32'(bus.out_idx),   m_idx);
    check({tag, ".out_count"}, 32'(bus.out_count), m_count);
  endtask

  // One clock cycle. It is entered and left 1 time unit after a rising edge.
  task automatic cyc(input string tag, input bit v, input logic [WIDTH-1:0] d,
                     input bit l, input bit r);
    bit acc;
    bit xfer;
    int mx;
    int mi;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
    #1;
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, (!m_valid || r)});
    acc  = v && (!m_valid || r);
    xfer = m_valid && r;
    @(posedge clk);
    if (xfer) m_valid = 1'b0;
    if (acc) begin
      frame.push_back(d);
      if (l || frame.size() == FRAME_LEN) begin
        mx = -1;
        mi = 0;
        foreach (frame[i]) begin
          if (int'(frame[i]) > mx) begin
            mx = int'(frame[i]);
            mi = i;
          end
        end
        m_valid = 1'b1;
        m_max   = 32'(mx);
        m_idx   = 32'(mi);
        m_count = 32'(frame.size());
        frame.delete();
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] s1[8] = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd15, 4'd0, 4'd7, 4'd15};
  logic [WIDTH-1:0] s6[8] = '{4'd7, 4'd7, 4'd7, 4'd6, 4'd7, 4'd2, 4'd1, 4'd0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    check_outputs("reset");
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-length frame: max 15, first at index 4.
    for (int i = 0; i < 8; i++) cyc("full", 1'b1, s1[i], 1'b0, 1'b1);
    check("full.direct_idx", 32'(bus.out_idx), 32'd4);
    cyc("drain1", 1'b0, '0, 1'b0, 1'b1);

    // Early close with a tie on the max; the next frame starts at index 0.
    cyc("early", 1'b1, 4'd5, 1'b0, 1'b1);
    cyc("early", 1'b1, 4'd1, 1'b0, 1'b1);
    cyc("early", 1'b1, 4'd5, 1'b1, 1'b1);
    cyc("next", 1'b1, 4'd2, 1'b0, 1'b1);
    cyc("next", 1'b1, 4'd9, 1'b1, 1'b1);
    cyc("drain2", 1'b0, '0, 1'b0, 1'b1);

    // Backpressure: the result holds and the input stalls, then the stream runs back-to-back.
    cyc("post", 1'b1, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("stall", 1'b1, 4'd9, 1'b0, 1'b0);
    cyc("release", 1'b1, 4'd3, 1'b1, 1'b1);
    cyc("drain3", 1'b0, '0, 1'b0, 1'b1);

    // Single-sample frames on consecutive cycles.
    cyc("single", 1'b1, 4'd4, 1'b1, 1'b1);
    cyc("single", 1'b1, 4'd10, 1'b1, 1'b1);
    cyc("single", 1'b1, 4'd2, 1'b1, 1'b1);
    cyc("drain4", 1'b0, '0, 1'b0, 1'b1);

    // Reset partway through a frame, then a full frame of zeros.
    for (int i = 1; i <= 4; i++) cyc("partial", 1'b1, 4'(i), 1'b0, 1'b1);
    async_reset("midreset");
    for (int i = 0; i < 8; i++) cyc("zeros", 1'b1, 4'd0, 1'b0, 1'b1);
    cyc("drain5", 1'b0, '0, 1'b0, 1'b1);

    // Tie rule across a full frame.
    for (int i = 0; i < 8; i++) cyc("ties", 1'b1, s6[i], 1'b0, 1'b1);
    cyc("drain6", 1'b0, '0, 1'b0, 1'b1);

    // Random traffic with random backpressure and early closes.
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          $urandom_range(0, 3) != 0,
          4'($urandom_range(0, 15)),
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
